// File: rtl/counter_pkg.sv
// Shared constants and helpers for the loadable up/down counter.
// Direction encoding and terminal-value lookup live here.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal count for a given width and direction, zero-extended to 32 bits.
  function automatic logic [31:0] terminal(
    input int   width,
    input logic dir
  );
    if (dir == DIR_UP) return (32'd1 << width) - 32'd1;
    return 32'd0;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the up/down counter.
// Produces next count, wrap flag and ripple-carry out.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic             sclr,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next,
  output logic             rco
);

  logic [31:0] term;
  logic        at_term;
  logic        count;

  always_comb begin
    term      = terminal(WIDTH, up);
    at_term   = ({{(32-WIDTH){1'b0}}, q} == term);
    count     = load_n & enp & ent & ~sclr;
    rco       = ent & at_term;
    wrap_next = count & at_term;
    q_next    = q;
    if (sclr) begin
      q_next = '0;
    end else if (!load_n) begin
      q_next = d;
    end else if (count) begin
      if (up == DIR_UP) q_next = q + WIDTH'(1);
      else              q_next = q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_counter4.sv
// Registered cascadable up/down counter; optional synchronous
// clear compiled in with COUNTER_SCLR_EN.
module updown_counter4
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
`ifdef COUNTER_SCLR_EN
  input  logic             sclr_n,
`endif
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             sclr;

`ifdef COUNTER_SCLR_EN
  assign sclr = ~sclr_n;
`else
  assign sclr = 1'b0;
`endif

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q        (q),
    .d        (d),
    .load_n   (load_n),
    .enp      (enp),
    .ent      (ent),
    .up       (up),
    .sclr     (sclr),
    .q_next   (q_next),
    .wrap_next(wrap_next),
    .rco      (rco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_updown_counter4.sv
// Directed bench for updown_counter4 with an expected-value queue
// and a two-stage cascade.
module tb_updown_counter4;
  import counter_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_n;
  logic [3:0] d;
  logic       enp;
  logic       ent;
  logic       up;
  logic       sclr_v;
  logic [3:0] q;
  logic       rco;
  logic       wrap;

  logic       c_load_n;
  logic [3:0] c_d0;
  logic [3:0] c_d1;
  logic       c_enp;
  logic       c_ent;
  logic       c_up;
  logic [3:0] cq0;
  logic [3:0] cq1;
  logic       crco0;
  logic       crco1;
  logic       cw0;
  logic       cw1;

  exp_t       sb[$];
  logic [3:0] mq;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  updown_counter4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load_n(load_n),
    .d     (d),
    .enp   (enp),
    .ent   (ent),
    .up    (up),
`ifdef COUNTER_SCLR_EN
    .sclr_n(sclr_v),
`endif
    .q     (q),
    .rco   (rco),
    .wrap  (wrap)
  );

  updown_counter4 #(.WIDTH(4)) c0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load_n(c_load_n),
    .d     (c_d0),
    .enp   (c_enp),
    .ent   (c_ent),
    .up    (c_up),
`ifdef COUNTER_SCLR_EN
    .sclr_n(1'b1),
`endif
    .q     (cq0),
    .rco   (crco0),
    .wrap  (cw0)
  );

  updown_counter4 #(.WIDTH(4)) c1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load_n(c_load_n),
    .d     (c_d1),
    .enp   (c_enp),
    .ent   (crco0),
    .up    (c_up),
`ifdef COUNTER_SCLR_EN
    .sclr_n(1'b1),
`endif
    .q     (cq1),
    .rco   (crco1),
    .wrap  (cw1)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the result, then compare.
  task automatic step(input logic ld, input logic [3:0] dv,
                      input logic p, input logic t, input logic u);
    exp_t        e;
    logic [31:0] tm;
    @(negedge clk);
    load_n = ld;
    d      = dv;
    enp    = p;
    ent    = t;
    up     = u;
    tm     = terminal(4, u);
    e.q    = mq;
    e.w    = 1'b0;
    if (!sclr_v) begin
      e.q = 4'h0;
    end else if (!ld) begin
      e.q = dv;
    end else if (p && t) begin
      e.q = u ? mq + 4'd1 : mq - 4'd1;
      e.w = (mq == tm[3:0]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    chk("q", 8'(q), 8'(e.q));
    chk("wrap", 8'(wrap), 8'(e.w));
    mq = e.q;
    tm = terminal(4, up);
    chk("rco", 8'(rco), 8'(ent && (mq == tm[3:0])));
  endtask

  initial begin
    rst_n    = 1'b1;
    load_n   = 1'b1;
    d        = 4'h0;
    enp      = 1'b0;
    ent      = 1'b1;
    up       = DIR_DOWN;
    sclr_v   = 1'b1;
    c_load_n = 1'b1;
    c_d0     = 4'h0;
    c_d1     = 4'h0;
    c_enp    = 1'b0;
    c_ent    = 1'b0;
    c_up     = DIR_UP;
    mq       = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_q", 8'(q), 8'h0);
    chk("rst_wrap", 8'(wrap), 8'h0);
    chk("rst_rco", 8'(rco), 8'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // load priority over count
    step(1'b0, 4'hA, 1'b1, 1'b1, DIR_UP);
    chk("load_a", 8'(q), 8'h0A);

    // reset mid-count at q = 9
    step(1'b0, 4'h8, 1'b1, 1'b1, DIR_UP);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_UP);
    chk("pre_rst", 8'(q), 8'h09);
    up = DIR_DOWN;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 8'(q), 8'h0);
    chk("arst_wrap", 8'(wrap), 8'h0);
    chk("arst_rco", 8'(rco), 8'h1);
    mq = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // up wrap
    step(1'b0, 4'hE, 1'b1, 1'b1, DIR_UP);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_UP);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_UP);
    chk("upwrap_w", 8'(wrap), 8'h1);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_UP);
    chk("upwrap_w1", 8'(wrap), 8'h0);

    // down wrap and direction switch
    step(1'b0, 4'h1, 1'b1, 1'b1, DIR_DOWN);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_DOWN);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_DOWN);
    chk("dnwrap_q", 8'(q), 8'h0F);
    chk("dnwrap_w", 8'(wrap), 8'h1);
    up = DIR_UP;
    #1;
    chk("dir_rco", 8'(rco), 8'h1);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_UP);
    chk("dir_q", 8'(q), 8'h0);

    // enable gating, terminal load
    step(1'b0, 4'hF, 1'b1, 1'b1, DIR_UP);
    chk("tload_w", 8'(wrap), 8'h0);
    step(1'b1, 4'h0, 1'b0, 1'b1, DIR_UP);
    chk("enp_hold", 8'(q), 8'h0F);
    step(1'b1, 4'h0, 1'b1, 1'b0, DIR_UP);
    chk("ent_rco", 8'(rco), 8'h0);
    step(1'b1, 4'h0, 1'b1, 1'b1, DIR_DOWN);
    step(1'b1, 4'h0, 1'b0, 1'b0, DIR_DOWN);

`ifdef COUNTER_SCLR_EN
    step(1'b0, 4'h7, 1'b1, 1'b1, DIR_UP);
    sclr_v = 1'b0;
    step(1'b0, 4'h5, 1'b1, 1'b1, DIR_UP);
    chk("sclr_q", 8'(q), 8'h0);
    sclr_v = 1'b1;
`endif

    // two-stage cascade from 8'hFE
    @(negedge clk);
    c_load_n = 1'b0;
    c_d0     = 4'hE;
    c_d1     = 4'hF;
    c_enp    = 1'b1;
    c_ent    = 1'b1;
    c_up     = DIR_UP;
    @(posedge clk);
    #1;
    chk("cas_fe", {cq1, cq0}, 8'hFE);
    @(negedge clk);
    c_load_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cas_ff", {cq1, cq0}, 8'hFF);
    chk("cas_rco1", 8'(crco1), 8'h1);
    chk("cas_w1a", 8'(cw1), 8'h0);
    @(posedge clk);
    #1;
    chk("cas_00", {cq1, cq0}, 8'h00);
    chk("cas_w1b", 8'(cw1), 8'h1);
    chk("cas_w0", 8'(cw0), 8'h1);
    @(posedge clk);
    #1;
    chk("cas_01", {cq1, cq0}, 8'h01);
    chk("cas_w1c", 8'(cw1), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter4.md
# updown_counter4

Synchronous, loadable, cascadable binary up/down counter, the registered counterpart of the team's combinational 4-bit count-next-state slices. It holds the count, applies load and enable priority, counts in either direction, and produces a ripple-carry output so N instances chain into wider counters. It sits in the benchmark-derived counter datapaths as the state-holding element driven by external load and enable logic.

## Interface

- WIDTH, 4, counter width in bits, minimum 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- load_n  in  1  synchronous parallel load, active-low.
- d  in  WIDTH  parallel load data.
- enp  in  1  count enable P; gates counting only.
- ent  in  1  count enable T, the cascade input; gates counting and rco.
- up  in  1  direction: 1 increments, 0 decrements.
- sclr_n  in  1  synchronous clear, active-low; present only with COUNTER_SCLR_EN.
- q  out  WIDTH  registered count.
- rco  out  1  ripple-carry out, combinational, the cascade output.
- wrap  out  1  registered one-cycle pulse on terminal wrap.

## Operation

- Next-state priority, highest first: rst_n low, then sclr_n low (if compiled in), then load_n low, then counting, then hold.
- Load: q <= d, whatever the values of enp, ent and up.
- Count condition: load_n high, enp high and ent high.
  - up = 1: q <= q + 1, modulo 2^WIDTH.
  - up = 0: q <= q - 1, modulo 2^WIDTH.
  - Otherwise q holds.
- Terminal state depends on direction: all-ones when up = 1, all-zeros when up = 0.
- rco = ent AND (q equals the terminal state for the current value of up). It does not depend on enp, so a cascade works like the 74x163.
- wrap: one register, set for exactly the cycle after any edge on which a count took q from terminal to its wrap value (all-ones to 0 counting up, 0 to all-ones counting down). A load or clear never sets wrap.
- Direction may change on any cycle. The new direction applies to that edge's count and immediately to rco.
- Arithmetic is unsigned WIDTH-bit. There is no saturation.

## Timing

- Reset values: q = 0 and wrap = 0. rco follows from the reset state, so rco = ent AND NOT up while in reset.
- Reset mid-operation: q clears and wrap clears asynchronously on the falling edge of rst_n. Release is synchronous to clk, and the first count happens on the first rising edge with rst_n high.
- Latency is one cycle from load, clear or count input to q. wrap follows q by the same edge. rco has zero latency from q, ent and up.
- Simultaneous load and count enable: load wins and q = d.
- Loading the terminal value raises rco in the next cycle if ent is high. wrap stays low.
- Cascade: stage k ent connects to stage k-1 rco, and all stages share clk, enp and up. Every stage updates on the same edge.

## Configuration

- COUNTER_SCLR_EN defined:
  - The sclr_n port exists.
  - Clear has priority over load and count and forces q = 0 on the next edge.
  - Clear does not set wrap.
- COUNTER_SCLR_EN undefined:
  - The sclr_n port is absent.
  - The priority chain starts at load.

## Structure

- Shared package counter_pkg holds:
  - the direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - a function returning the terminal value for a width and direction, used by both RTL and bench.
- One sub-module is natural: counter_next, purely combinational. It maps (q, d, load_n, enp, ent, up, sclr) to the next q, the wrap flag and rco. The top holds the registers only.

## Test plan

- Reset: pulse rst_n low mid-count with q = 4'h9 → q = 0 and wrap = 0 immediately, with no clock edge. With up = 0 and ent = 1, rco = 1 during reset.
- Load priority: load_n = 0, d = 4'hA, enp = ent = 1, up = 1 → q = 4'hA next cycle, wrap = 0.
- Up wrap: load 4'hE, count up for 2 edges → q = F then 0. rco = 1 only while q = F. wrap = 1 for the single cycle after reaching 0.
- Down wrap and direction switch: load 4'h1, up = 0 → q = 0 then F, and wrap pulses. Set up = 1 at q = F → rco = 1 at once, and the next edge gives q = 0.
- Enable gating: enp = 0, ent = 1 at q = F with up = 1 → q holds and rco = 1. enp = 1, ent = 0 → q holds and rco = 0.
- Cascade of two WIDTH = 4 instances counting up from 8'hFE → 8'hFF, then 8'h00, with the high-stage wrap asserted once. With COUNTER_SCLR_EN, sclr_n = 0 while load_n = 0 → q = 0.
